// File: rtl/ram_512_arbiter.sv
// Round-robin arbiter and clear sequencer placing two req/ready requesters in front of one ram_512.
// Read data returns registered one cycle after acceptance; CLEAR fills all 512 words with CLEAR_VALUE.
module ram_512_arbiter #(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [15:0] CLEAR_VALUE    = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear_start,
  output logic        busy,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [8:0]  a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ready,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [8:0]  b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ready,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  output logic [15:0] ram_in,
  output logic [8:0]  ram_address,
  output logic        ram_load,
  input  logic [15:0] ram_out
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_SERVE = 1'b1} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;

  state_t      state_r, state_next_s;
  logic [8:0]  clr_addr_r;
  logic        ptr_r;
  logic        grant_a_s, grant_b_s;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: CLEAR runs exactly 512 cycles, clear_start only honoured in SERVE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_addr_r == 9'd511) begin
          state_next_s = ST_SERVE;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_SERVE: begin
        if (clear_start) begin
          state_next_s = ST_CLEAR;
        end else begin
          state_next_s = ST_SERVE;
        end
      end
      default: state_next_s = RESET_STATE;
    endcase
  end

  // Output logic: grant selection and RAM port steering; ptr_r=1 favours B
  always_comb begin
    grant_a_s   = 1'b0;
    grant_b_s   = 1'b0;
    busy        = 1'b0;
    ram_address = 9'd0;
    ram_in      = 16'h0000;
    ram_load    = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        busy        = 1'b1;
        ram_address = clr_addr_r;
        ram_in      = CLEAR_VALUE;
        ram_load    = reset_n;
      end
      ST_SERVE: begin
        if (!clear_start) begin
          if (a_req && b_req) begin
            grant_a_s = ~ptr_r;
            grant_b_s = ptr_r;
          end else begin
            grant_a_s = a_req;
            grant_b_s = b_req;
          end
        end else begin
          grant_a_s = 1'b0;
          grant_b_s = 1'b0;
        end
        if (grant_a_s) begin
          ram_address = a_addr;
          ram_in      = a_wdata;
          ram_load    = a_we & reset_n;
        end else if (grant_b_s) begin
          ram_address = b_addr;
          ram_in      = b_wdata;
          ram_load    = b_we & reset_n;
        end else begin
          ram_load    = 1'b0;
        end
      end
      default: busy = 1'b0;
    endcase
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;

  // Clear address counter and round-robin pointer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clr_addr_r <= 9'd0;
      ptr_r      <= 1'b0;
    end else begin
      if (state_r == ST_CLEAR) begin
        clr_addr_r <= (clr_addr_r == 9'd511) ? 9'd0 : clr_addr_r + 9'd1;
      end else begin
        clr_addr_r <= 9'd0;
      end
      if (grant_a_s) begin
        ptr_r <= 1'b1;
      end else if (grant_b_s) begin
        ptr_r <= 1'b0;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // Registered read returns; rdata holds until that requester's next read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_rvalid <= 1'b0;
      a_rdata  <= 16'h0000;
      b_rvalid <= 1'b0;
      b_rdata  <= 16'h0000;
    end else begin
      a_rvalid <= grant_a_s & ~a_we;
      b_rvalid <= grant_b_s & ~b_we;
      if (grant_a_s && !a_we) begin
        a_rdata <= ram_out;
      end else begin
        a_rdata <= a_rdata;
      end
      if (grant_b_s && !b_we) begin
        b_rdata <= ram_out;
      end else begin
        b_rdata <= b_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_512_arbiter.sv
// Directed bench for ram_512_arbiter with a behavioural ram_512 attached.
module tb_ram_512_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clear_start;
  logic        busy;
  logic        a_req, a_we, a_ready, a_rvalid;
  logic [8:0]  a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic        b_req, b_we, b_ready, b_rvalid;
  logic [8:0]  b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic [15:0] ram_in, ram_out;
  logic [8:0]  ram_address;
  logic        ram_load;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ram_512_arbiter dut (
    .clock(clock), .reset_n(reset_n), .clear_start(clear_start), .busy(busy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load), .ram_out(ram_out)
  );

  // Behavioural ram_512: combinational read, write on rising edge when load=1
  logic [15:0] mem [512];
  always @(posedge clock) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  typedef struct {
    logic        a_req, a_we; logic [8:0] a_addr; logic [15:0] a_wdata;
    logic        b_req, b_we; logic [8:0] b_addr; logic [15:0] b_wdata;
    logic        ea_rdy, eb_rdy, ea_rv, eb_rv;
    logic [15:0] ea_rd, eb_rd;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ar, aw, input logic [8:0] aa, input logic [15:0] ad,
                              input logic br, bw, input logic [8:0] ba, input logic [15:0] bd,
                              input logic ery, ebry, erv, ebrv,
                              input logic [15:0] erd, ebrd);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    v.ea_rdy = ery; v.eb_rdy = ebry; v.ea_rv = erv; v.eb_rv = ebrv;
    v.ea_rd = erd; v.eb_rd = ebrd;
    return v;
  endfunction

  // Runs one clear sequence from the current cycle; returns number of busy cycles
  task automatic run_clear(output int cnt, input bool_poke);
    cnt = 0;
    while (busy && cnt < 600) begin
      chk("clr_load", ram_load, 1'b1);
      chk("clr_addr", ram_address, cnt[8:0]);
      chk("clr_in", ram_in, 16'h0000);
      chk("clr_a_ready", a_ready, 1'b0);
      chk("clr_b_ready", b_ready, 1'b0);
      cnt++;
      if (bool_poke && cnt == 100) clear_start = 1'b1;
      if (cnt == 103) clear_start = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int cnt;
    reset_n = 1'b0; clear_start = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 9'd0; a_wdata = 16'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 9'd0; b_wdata = 16'h0;

    //           a_req we addr    wdata     b_req we addr    wdata    ardy brdy arv brv  a_rdata   b_rdata
    vecs[0]  = mk(1, 1, 9'h1A5, 16'hBEEF, 0, 0, 9'h000, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000);
    vecs[1]  = mk(1, 0, 9'h1A5, 16'h0000, 0, 0, 9'h000, 16'h0000, 1, 0, 1, 0, 16'hBEEF, 16'h0000);
    vecs[2]  = mk(1, 1, 9'h003, 16'h0003, 0, 0, 9'h000, 16'h0000, 1, 0, 0, 0, 16'hBEEF, 16'h0000);
    vecs[3]  = mk(0, 0, 9'h000, 16'h0000, 1, 1, 9'h004, 16'h0004, 0, 1, 0, 0, 16'hBEEF, 16'h0000);
    vecs[4]  = mk(0, 0, 9'h000, 16'h0000, 1, 0, 9'h12C, 16'h0000, 0, 1, 0, 1, 16'hBEEF, 16'h0000);
    vecs[5]  = mk(1, 0, 9'h003, 16'h0000, 1, 0, 9'h004, 16'h0000, 1, 0, 1, 0, 16'h0003, 16'h0000);
    vecs[6]  = mk(1, 0, 9'h003, 16'h0000, 1, 0, 9'h004, 16'h0000, 0, 1, 0, 1, 16'h0003, 16'h0004);
    vecs[7]  = mk(1, 0, 9'h003, 16'h0000, 1, 0, 9'h004, 16'h0000, 1, 0, 1, 0, 16'h0003, 16'h0004);
    vecs[8]  = mk(1, 0, 9'h003, 16'h0000, 1, 0, 9'h004, 16'h0000, 0, 1, 0, 1, 16'h0003, 16'h0004);
    vecs[9]  = mk(1, 0, 9'h003, 16'h0000, 1, 0, 9'h004, 16'h0000, 1, 0, 1, 0, 16'h0003, 16'h0004);
    vecs[10] = mk(1, 0, 9'h003, 16'h0000, 1, 0, 9'h004, 16'h0000, 0, 1, 0, 1, 16'h0003, 16'h0004);
    vecs[11] = mk(1, 0, 9'h003, 16'h0000, 0, 0, 9'h000, 16'h0000, 1, 0, 1, 0, 16'h0003, 16'h0004);
    vecs[12] = mk(0, 0, 9'h000, 16'h0000, 1, 0, 9'h004, 16'h0000, 0, 1, 0, 1, 16'h0003, 16'h0004);
    vecs[13] = mk(0, 0, 9'h000, 16'h0000, 1, 0, 9'h004, 16'h0000, 0, 1, 0, 1, 16'h0003, 16'h0004);
    vecs[14] = mk(0, 0, 9'h000, 16'h0000, 1, 0, 9'h004, 16'h0000, 0, 1, 0, 1, 16'h0003, 16'h0004);
    vecs[15] = mk(1, 0, 9'h003, 16'h0000, 1, 0, 9'h004, 16'h0000, 1, 0, 1, 0, 16'h0003, 16'h0004);
    vecs[16] = mk(1, 0, 9'h003, 16'h0000, 1, 0, 9'h004, 16'h0000, 0, 1, 0, 1, 16'h0003, 16'h0004);
    vecs[17] = mk(0, 0, 9'h000, 16'h0000, 1, 1, 9'h1A5, 16'h7777, 0, 1, 0, 0, 16'h0003, 16'h0004);
    vecs[18] = mk(1, 0, 9'h1A5, 16'h0000, 0, 0, 9'h000, 16'h0000, 1, 0, 1, 0, 16'h7777, 16'h0004);

    // Reset state
    #12;
    chk("rst_busy", busy, 1'b1);
    chk("rst_load", ram_load, 1'b0);
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_b_rvalid", b_rvalid, 1'b0);
    chk("rst_a_rdata", a_rdata, 16'h0000);
    chk("rst_b_rdata", b_rdata, 16'h0000);

    // Power-on clear: exactly 512 cycles over addresses 0..511
    @(negedge clock); reset_n = 1'b1; #1;
    run_clear(cnt, 1'b0);
    chk("clr_cycles", cnt, 512);

    // Table-driven vectors
    for (int i = 0; i < 19; i++) begin
      a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
      #1;
      chk($sformatf("v%0d_a_ready", i), a_ready, vecs[i].ea_rdy);
      chk($sformatf("v%0d_b_ready", i), b_ready, vecs[i].eb_rdy);
      @(posedge clock); #1;
      chk($sformatf("v%0d_a_rvalid", i), a_rvalid, vecs[i].ea_rv);
      chk($sformatf("v%0d_b_rvalid", i), b_rvalid, vecs[i].eb_rv);
      chk($sformatf("v%0d_a_rdata", i), a_rdata, vecs[i].ea_rd);
      chk($sformatf("v%0d_b_rdata", i), b_rdata, vecs[i].eb_rd);
    end

    // clear_start together with an A write: no grant, then A waits out the clear
    a_req = 1'b1; a_we = 1'b1; a_addr = 9'd5; a_wdata = 16'h1234;
    b_req = 1'b0; b_we = 1'b0;
    clear_start = 1'b1;
    #1;
    chk("cs_a_ready", a_ready, 1'b0);
    chk("cs_load", ram_load, 1'b0);
    @(posedge clock); #1;
    clear_start = 1'b0;
    chk("cs_busy", busy, 1'b1);
    run_clear(cnt, 1'b1);
    chk("cs_clr_cycles", cnt, 512);
    chk("cs_a_ready_after", a_ready, 1'b1);
    chk("cs_load_after", ram_load, 1'b1);
    @(posedge clock); #1;
    a_we = 1'b0;
    #1;
    chk("rd5_a_ready", a_ready, 1'b1);
    @(posedge clock); #1;
    chk("rd5_a_rvalid", a_rvalid, 1'b1);
    chk("rd5_a_rdata", a_rdata, 16'h1234);

    // Reset pulsed the cycle after acceptance
    a_req = 1'b0;
    reset_n = 1'b0; #1;
    chk("mr_a_rvalid", a_rvalid, 1'b0);
    chk("mr_a_rdata", a_rdata, 16'h0000);
    chk("mr_busy", busy, 1'b1);
    chk("mr_load", ram_load, 1'b0);
    #2; reset_n = 1'b1; #1;
    run_clear(cnt, 1'b0);
    chk("mr_clr_cycles", cnt, 512);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_512_arbiter.md
Name: ram_512_arbiter

Overview:
- Two-requester round-robin arbiter and initialiser for one ram_512 instance: combinational read, write on the clock edge when load=1.
- Requester A (CPU data port) and requester B (DMA/peripheral port) share the RAM through a req/ready handshake.
- Read data is registered and returned one cycle after acceptance.
- An optional built-in clear sequencer fills all 512 words with CLEAR_VALUE after reset or on command.

Parameters:
- CLEAR_ON_RESET, 1, when 1, reset enters CLEAR state; when 0, reset enters SERVE state.
- CLEAR_VALUE, 16'h0000, word written to every address during CLEAR.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clear_start  input  1  request a full-memory clear; sampled in SERVE only.
- busy  output  1  high while in CLEAR.
- a_req  input  1  A requests an access; A holds it with addr/we/wdata stable until a_ready.
- a_we  input  1  1=write, 0=read.
- a_addr  input  9  word address.
- a_wdata  input  16  write data.
- a_ready  output  1  combinational grant; transfer occurs when a_req & a_ready.
- a_rvalid  output  1  one-cycle pulse, a_rdata valid.
- a_rdata  output  16  registered read data.
- b_req, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: identical to the A set, for requester B.
- ram_in  output  16  to ram_512 in.
- ram_address  output  9  to ram_512 address.
- ram_load  output  1  to ram_512 load.
- ram_out  input  16  from ram_512 out.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to CLEAR if CLEAR_ON_RESET, else SERVE; clr_addr=0; priority pointer=A.
  - a_rvalid=b_rvalid=0; a_rdata=b_rdata=0.
  - ram_load forced 0 while reset_n low.
  - busy=CLEAR_ON_RESET.
- CLEAR:
  - ram_address=clr_addr, ram_in=CLEAR_VALUE, ram_load=1.
  - clr_addr increments every cycle.
  - In the cycle with clr_addr=511, next state is SERVE and clr_addr returns to 0. Total: exactly 512 cycles.
  - a_ready=b_ready=0; busy=1; clear_start ignored; requests wait.
- SERVE, grant (combinational):
  - clear_start=1 has priority: no grant this cycle; next state CLEAR.
  - Otherwise, a single request is granted.
  - When both request, the requester named by the priority pointer is granted.
  - After any transfer, the pointer moves to the other requester. Alternation under contention is A,B,A,B...
- SERVE, datapath: ram_address/ram_in come from the granted requester; ram_load = granted & we.
  - With no grant: ram_load=0, ram_address=0, ram_in=0.
- Reads:
  - On the accepting edge, x_rdata <= ram_out and x_rvalid <= 1 for exactly one cycle.
  - x_rdata holds its value until the next read by that requester.
  - Latency is 1 cycle from acceptance.
  - Back-to-back reads give consecutive rvalid pulses.
- Writes:
  - Committed at the accepting edge; no rvalid.
  - A read of the same address in the next cycle, from either requester, returns the new data.
- Each requester has at most one transfer per cycle; the RAM has one access per cycle total.
- Reset mid-CLEAR or mid-read: the sequence restarts and any pending rvalid is dropped.
- Re-issuing clear_start while busy has no effect.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> busy=1 for exactly 512 cycles, ram_load=1 on addresses 0..511 with ram_in=0000; a read of addr 300 afterward returns 0000.
- A writes 16'hBEEF to addr 9'h1A5, then next cycle reads addr 9'h1A5 -> a_ready both cycles; a_rvalid one cycle after the read with a_rdata=BEEF; b_rvalid stays 0.
- A and B both hold read requests for 6 cycles (A addr 3, B addr 4; memory preloaded 0x0003/0x0004) -> grants A,B,A,B,A,B; each rvalid pulse carries 0x0003 or 0x0004 correctly.
- Only B requests for 3 cycles after an A grant -> B granted every cycle; when A requests next alongside B, A is granted first.
- clear_start asserted in the same cycle as a_req -> a_ready=0 that cycle, busy=1 next cycle; A's write of 0x1234 is accepted only after the 512 clear cycles.
- reset_n pulsed low mid-read (the cycle after acceptance) -> a_rvalid=0 and a_rdata=0 immediately, CLEAR restarts at address 0.
